// File: rtl/lighthouse_pulse_decoder.sv
// lighthouse_pulse_decoder
//   Per-sensor front end for the tracking fabric. It synchronises one raw
//   photodiode envelope bit and measures the width of every light pulse.
//   Pulses are classified as lighthouse sync flashes, which carry the
//   skip/data/axis code, or as laser sweeps. Each sweep seen while locked
//   produces one timestamped record on a valid/ready handshake.
//
// Ports
//   clock            system clock (50 MHz); all counts are in these cycles
//   reset            asynchronous, active-high
//   sensor_i         raw envelope, high while light is present (asynchronous)
//   enable           decoder enable; low forces IDLE and forgets sync history
//   sweep_valid      record register holds a sweep
//   sweep_ready      consumer accepts the record this cycle
//   sweep_duration   cycles from the reference sync rise to the sweep rise
//   sweep_axis       axis bit of the reference sync
//   sweep_data       data bit of the reference sync
//   sweep_lighthouse 0 = first station of the pair, 1 = second
//   sweep_width      sweep pulse width in cycles
//   sync_locked      high while a reference sync is held
//   overflow         one-cycle pulse when a sweep is dropped
module lighthouse_pulse_decoder #(
  parameter int GLITCH_MIN   = 10,
  parameter int SWEEP_MAX    = 1000,
  parameter int SYNC_MIN     = 2500,
  parameter int SYNC_MAX     = 7000,
  parameter int SYNC_BASE    = 2865,
  parameter int SYNC_STEP    = 521,
  parameter int PAIR_GAP     = 20000,
  parameter int SWEEP_WINDOW = 420000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sensor_i,
  input  logic        enable,
  output logic        sweep_valid,
  input  logic        sweep_ready,
  output logic [19:0] sweep_duration,
  output logic        sweep_axis,
  output logic        sweep_data,
  output logic        sweep_lighthouse,
  output logic [9:0]  sweep_width,
  output logic        sync_locked,
  output logic        overflow
);

  localparam logic [12:0] W_SAT     = 13'h1fff;
  localparam logic [12:0] GLITCH_L  = 13'(GLITCH_MIN);
  localparam logic [12:0] SWEEP_L   = 13'(SWEEP_MAX);
  localparam logic [12:0] SYNC_LO_L = 13'(SYNC_MIN);
  localparam logic [12:0] SYNC_HI_L = 13'(SYNC_MAX);
  localparam logic [19:0] PAIR_L    = 20'(PAIR_GAP);
  localparam logic [19:0] WINDOW_L  = 20'(SWEEP_WINDOW);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  // Width counter increment that sticks at full scale
  function automatic logic [12:0] sat_inc(input logic [12:0] v);
    return (v == W_SAT) ? v : v + 13'd1;
  endfunction

  // Number of code thresholds the pulse width reaches (0..7)
  function automatic logic [2:0] sync_code(input logic [12:0] w);
    logic [2:0] c;
    c = 3'd0;
    for (int k = 1; k <= 7; k++) begin
      if (w >= 13'(SYNC_BASE + k * SYNC_STEP)) c = c + 3'd1;
    end
    return c;
  endfunction

  state_t      state;
  logic        sens_p0, sens_p1, sens_p2;
  logic [19:0] tick;
  logic [19:0] rise_ts;
  logic [19:0] ref_ts;
  logic [19:0] prev_sync_ts;
  logic        in_pulse;
  logic        have_sync;
  logic [12:0] w_cnt;
  logic        ref_axis, ref_data, ref_lh;

  logic        rise, fall, pulse_end;
  logic        is_sweep, is_sync;
  logic        sync_evt, sweep_evt;
  logic        first_sync, timed_out, load;
  logic [2:0]  code;
  logic [19:0] since_ref, since_prev;

  assign rise       = sens_p1 & ~sens_p2;
  assign fall       = ~sens_p1 & sens_p2;
  // Only falls that close a measured pulse are classified
  assign pulse_end  = fall & in_pulse & enable;
  assign is_sweep   = (w_cnt >= GLITCH_L) && (w_cnt < SWEEP_L);
  assign is_sync    = (w_cnt >= SYNC_LO_L) && (w_cnt <= SYNC_HI_L);
  assign code       = sync_code(w_cnt);
  assign sync_evt   = pulse_end & is_sync;
  assign sweep_evt  = pulse_end & is_sweep & (state == LOCKED);
  assign since_prev = rise_ts - prev_sync_ts;
  assign since_ref  = tick - ref_ts;
  assign first_sync = ~have_sync | (since_prev >= PAIR_L);
  assign timed_out  = since_ref >= WINDOW_L;
  assign load       = sweep_evt & (~sweep_valid | sweep_ready);

  // p0/p1: two-flop synchroniser; p2: edge-detect history.
  // Resetting these high means a pulse already present at reset release
  // never shows a rise, and its trailing fall finds in_pulse clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sens_p0  <= 1'b1;
      sens_p1  <= 1'b1;
      sens_p2  <= 1'b1;
      tick     <= '0;
      rise_ts  <= '0;
      in_pulse <= 1'b0;
      w_cnt    <= '0;
    end else begin
      sens_p0 <= sensor_i;
      sens_p1 <= sens_p0;
      sens_p2 <= sens_p1;
      tick    <= tick + 20'd1;
      if (rise) begin
        rise_ts  <= tick;
        in_pulse <= 1'b1;
        w_cnt    <= 13'd1;   // the rise cycle itself is the first high cycle
      end else if (sens_p1) begin
        w_cnt <= sat_inc(w_cnt);
      end
      if (fall) in_pulse <= 1'b0;
    end
  end

  // Sync tracking and lock state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sync_locked  <= 1'b0;
      have_sync    <= 1'b0;
      prev_sync_ts <= '0;
      ref_ts       <= '0;
      ref_axis     <= 1'b0;
      ref_data     <= 1'b0;
      ref_lh       <= 1'b0;
    end else if (!enable) begin
      state       <= IDLE;
      sync_locked <= 1'b0;
      have_sync   <= 1'b0;
    end else if (sync_evt) begin
      have_sync    <= 1'b1;
      prev_sync_ts <= rise_ts;
      if (!code[2]) begin
        // Latest non-skip sync becomes the reference, even when already locked
        ref_ts      <= rise_ts;
        ref_axis    <= code[0];
        ref_data    <= code[1];
        ref_lh      <= ~first_sync;
        state       <= LOCKED;
        sync_locked <= 1'b1;
      end else if (state == LOCKED && timed_out) begin
        state       <= IDLE;
        sync_locked <= 1'b0;
      end
    end else if (state == LOCKED && timed_out) begin
      state       <= IDLE;
      sync_locked <= 1'b0;
    end
  end

  // Single-entry record register; reload allowed in the draining cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sweep_valid      <= 1'b0;
      sweep_duration   <= '0;
      sweep_axis       <= 1'b0;
      sweep_data       <= 1'b0;
      sweep_lighthouse <= 1'b0;
      sweep_width      <= '0;
      overflow         <= 1'b0;
    end else begin
      overflow <= sweep_evt & ~load;
      if (load) begin
        sweep_valid      <= 1'b1;
        sweep_duration   <= rise_ts - ref_ts;
        sweep_axis       <= ref_axis;
        sweep_data       <= ref_data;
        sweep_lighthouse <= ref_lh;
        sweep_width      <= w_cnt[9:0];
      end else if (sweep_ready) begin
        sweep_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lighthouse_pulse_decoder.sv
// Testbench for lighthouse_pulse_decoder. The sweep window is shortened to
// 10000 cycles and sync-to-sweep times are scaled down to keep runs short;
// pulse widths and code thresholds keep their default values.
module tb_lighthouse_pulse_decoder;

  localparam int WINDOW = 10000;

  logic        clock = 1'b0;
  logic        reset;
  logic        sensor_i;
  logic        enable;
  logic        sweep_ready;
  logic        sweep_valid;
  logic [19:0] sweep_duration;
  logic        sweep_axis;
  logic        sweep_data;
  logic        sweep_lighthouse;
  logic [9:0]  sweep_width;
  logic        sync_locked;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  int ovf_cnt = 0;
  int xfer_cnt = 0;

  typedef struct {
    int sync_w;
    int sweep_w;
    bit lock;
    bit rec;
    bit axis;
    bit data;
  } vec_t;

  vec_t vecs[10];

  lighthouse_pulse_decoder #(.SWEEP_WINDOW(WINDOW)) dut (
    .clock            (clock),
    .reset            (reset),
    .sensor_i         (sensor_i),
    .enable           (enable),
    .sweep_valid      (sweep_valid),
    .sweep_ready      (sweep_ready),
    .sweep_duration   (sweep_duration),
    .sweep_axis       (sweep_axis),
    .sweep_data       (sweep_data),
    .sweep_lighthouse (sweep_lighthouse),
    .sweep_width      (sweep_width),
    .sync_locked      (sync_locked),
    .overflow         (overflow)
  );

  always #10 clock = ~clock;

  // Transfer and overflow counters, sampled at the active edge
  always @(posedge clock) begin
    if (overflow) ovf_cnt <= ovf_cnt + 1;
    if (sweep_valid && sweep_ready) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input int w);
    sensor_i = 1'b1;
    step(w);
    sensor_i = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_history();
    enable = 1'b0;
    step(2);
    enable = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_o;
    int base_x;

    reset = 1'b1;
    enable = 1'b0;
    sweep_ready = 1'b1;
    sensor_i = 1'b0;

    //            sync_w sweep_w lock rec axis data
    vecs[0] = '{3125, 300,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{3646, 500,  1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{4000, 10,   1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{4500, 999,  1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{3125, 1000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{3125, 9,    1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2500, 200,  1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{2499, 200,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{5208, 200,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{3386, 100,  1'b1, 1'b1, 1'b1, 1'b0};

    step(3);
    chk("rst_valid",    int'(sweep_valid), 0);
    chk("rst_locked",   int'(sync_locked), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_duration", int'(sweep_duration), 0);
    chk("rst_width",    int'(sweep_width), 0);
    reset = 1'b0;
    step(3);
    enable = 1'b1;
    step(2);

    // Table: sync, then a sweep rising 400 cycles after the sync fall
    for (int i = 0; i < 10; i++) begin
      clear_history();
      chk($sformatf("v%0d_idle", i), int'(sync_locked), 0);
      pulse(vecs[i].sync_w);
      step(3);
      chk($sformatf("v%0d_lock", i), int'(sync_locked), int'(vecs[i].lock));
      step(397);
      pulse(vecs[i].sweep_w);
      step(2);
      chk($sformatf("v%0d_early", i), int'(sweep_valid), 0);
      step(1);
      chk($sformatf("v%0d_valid", i), int'(sweep_valid), int'(vecs[i].rec));
      if (vecs[i].rec) begin
        chk($sformatf("v%0d_dur", i), int'(sweep_duration), vecs[i].sync_w + 400);
        chk($sformatf("v%0d_width", i), int'(sweep_width), vecs[i].sweep_w);
        chk($sformatf("v%0d_axis", i), int'(sweep_axis), int'(vecs[i].axis));
        chk($sformatf("v%0d_data", i), int'(sweep_data), int'(vecs[i].data));
        chk($sformatf("v%0d_lh", i), int'(sweep_lighthouse), 0);
      end
      chk($sformatf("v%0d_ovf", i), int'(overflow), 0);
      step(1);
      chk($sformatf("v%0d_drained", i), int'(sweep_valid), 0);
    end

    // Pair: skip sync, then an axis sync 6000 later, sweep 4000 after that
    clear_history();
    pulse(5208);
    step(792);
    chk("pair_skip_nolock", int'(sync_locked), 0);
    pulse(3646);
    step(3);
    chk("pair_lock", int'(sync_locked), 1);
    step(351);
    pulse(300);
    step(3);
    chk("pair_valid", int'(sweep_valid), 1);
    chk("pair_dur",   int'(sweep_duration), 4000);
    chk("pair_axis",  int'(sweep_axis), 1);
    chk("pair_data",  int'(sweep_data), 0);
    chk("pair_lh",    int'(sweep_lighthouse), 1);
    step(1);

    // Glitch and out-of-band pulse while locked leave the reference alone
    clear_history();
    base_o = ovf_cnt;
    base_x = xfer_cnt;
    pulse(3125);
    step(175);
    pulse(5);
    step(200);
    pulse(1500);
    step(995);
    chk("rej_no_record", xfer_cnt - base_x, 0);
    chk("rej_no_ovf",    ovf_cnt - base_o, 0);
    chk("rej_locked",    int'(sync_locked), 1);
    pulse(300);
    step(3);
    chk("rej_valid", int'(sweep_valid), 1);
    chk("rej_dur",   int'(sweep_duration), 6000);
    chk("rej_width", int'(sweep_width), 300);
    step(1);

    // Timeout: lock drops exactly at the window boundary
    clear_history();
    pulse(3125);
    step(10002 - 3125);
    chk("to_locked_last", int'(sync_locked), 1);
    step(1);
    chk("to_unlocked", int'(sync_locked), 0);
    base_x = xfer_cnt;
    step(497);
    pulse(300);
    step(5);
    chk("to_no_record", xfer_cnt - base_x, 0);
    chk("to_valid",     int'(sweep_valid), 0);

    // Back-pressure: first record held, second dropped with one overflow
    clear_history();
    sweep_ready = 1'b0;
    base_o = ovf_cnt;
    pulse(3125);
    step(875);
    pulse(300);
    step(3);
    chk("bp_first_valid", int'(sweep_valid), 1);
    chk("bp_first_dur",   int'(sweep_duration), 4000);
    step(297);
    pulse(300);
    step(3);
    chk("bp_ovf_pulse", int'(overflow), 1);
    step(1);
    chk("bp_ovf_low",   int'(overflow), 0);
    chk("bp_ovf_count", ovf_cnt - base_o, 1);
    chk("bp_held_valid", int'(sweep_valid), 1);
    chk("bp_held_dur",   int'(sweep_duration), 4000);
    base_x = xfer_cnt;
    sweep_ready = 1'b1;
    step(1);
    chk("bp_drained", int'(sweep_valid), 0);
    step(2);
    chk("bp_xfer_count", xfer_cnt - base_x, 1);

    // Reset in the middle of a sync pulse
    chk("rr_locked_pre", int'(sync_locked), 1);
    sensor_i = 1'b1;
    step(1000);
    reset = 1'b1;
    #1;
    chk("rr_valid",    int'(sweep_valid), 0);
    chk("rr_locked",   int'(sync_locked), 0);
    chk("rr_duration", int'(sweep_duration), 0);
    chk("rr_width",    int'(sweep_width), 0);
    chk("rr_overflow", int'(overflow), 0);
    step(2);
    reset = 1'b0;
    step(2123);
    sensor_i = 1'b0;
    step(10);
    chk("rr_trailing_nolock", int'(sync_locked), 0);
    chk("rr_trailing_valid",  int'(sweep_valid), 0);
    pulse(3125);
    step(3);
    chk("rr_relock", int'(sync_locked), 1);
    step(397);
    pulse(300);
    step(3);
    chk("rr_valid_after", int'(sweep_valid), 1);
    chk("rr_dur_after",   int'(sweep_duration), 3525);
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lighthouse_pulse_decoder.md
# lighthouse_pulse_decoder

Per-sensor front end for the DarkRoom tracking fabric. It conditions one raw photodiode envelope bit, measures every light pulse, classifies pulses as lighthouse sync flashes (decoding the skip/data/axis code) or laser sweeps, and emits one timestamped sweep record per valid sweep over a valid/ready handshake. Sixteen instances sit directly upstream of the sensor-signal conduit of the tracking component. Each instance feeds one bit of the 16-bit sensor bus plus its sweep record stream.

## Interface
Parameters (counts in 50 MHz clock cycles):
- GLITCH_MIN, 10: pulses shorter than this are ignored entirely.
- SWEEP_MAX, 1000: a pulse with GLITCH_MIN ≤ W < SWEEP_MAX is a sweep.
- SYNC_MIN, 2500: a pulse with SYNC_MIN ≤ W ≤ SYNC_MAX is a sync.
- SYNC_MAX, 7000: upper bound for a sync pulse.
- SYNC_BASE, 2865: base width for sync code thresholds.
- SYNC_STEP, 521: step between sync code thresholds.
- PAIR_GAP, 20000: sync-to-sync rise gap that separates lighthouse pairs.
- SWEEP_WINDOW, 420000: maximum sync-to-sweep time; must be < 2^20.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- sensor_i  in  1  raw envelope, high while light is present; asynchronous.
- enable  in  1  decoder enable.
- sweep_valid  out  1  record available.
- sweep_ready  in  1  consumer accepts the record.
- sweep_duration  out  20  cycles from the reference sync rise to the sweep rise.
- sweep_axis  out  1  axis bit of the reference sync.
- sweep_data  out  1  data bit of the reference sync.
- sweep_lighthouse  out  1  0 = first station of the pair, 1 = second.
- sweep_width  out  10  sweep pulse width in cycles.
- sync_locked  out  1  high in state LOCKED.
- overflow  out  1  one-cycle pulse when a sweep is dropped.

## Operation
- Input path: two-flop synchronizer to s2, then a third flop (s3) for edge detection. Rise is s2 & !s3; fall is !s2 & s3.
- Free-running 20-bit tick counter that wraps modulo 2^20. All time differences are modulo 2^20.
- On each rise: rise_ts <= tick; in_pulse <= 1; the 13-bit width counter W is cleared.
- While s2 is high: W increments each cycle and saturates at 8191.
- A fall with in_pulse = 0 (for example a pulse already high at reset release) is ignored.
- Sync code: code = number of k in 1..7 with W ≥ SYNC_BASE + k·SYNC_STEP.
  - skip = code[2], data = code[1], axis = code[0].
- Sync classification at fall:
  - first = (no prior sync since IDLE) or (rise_ts − prev_sync_ts ≥ PAIR_GAP).
  - Then prev_sync_ts <= rise_ts.
  - If skip = 0: ref_ts <= rise_ts; latch axis and data; lighthouse <= !first; state <= LOCKED. This happens even if already LOCKED; the latest sync wins.
- Sweep classification at fall, LOCKED only:
  - Record: duration = rise_ts − ref_ts; width = W[9:0].
  - Every sweep is reported; reflections are the consumer's problem.
  - In IDLE, sweeps are ignored.
- Pulses with SWEEP_MAX ≤ W < SYNC_MIN, W > SYNC_MAX, or W < GLITCH_MIN are discarded. State and timestamps are unchanged; only rise_ts is overwritten.
- States: IDLE and LOCKED.
  - LOCKED → IDLE when tick − ref_ts ≥ SWEEP_WINDOW, or when enable = 0.
  - enable = 0 also blocks all classification and clears the sync history.
- Output register (1 entry):
  - Loads when a sweep is classified and (!sweep_valid or sweep_ready).
  - A transfer occurs when sweep_valid & sweep_ready.
  - If the register is full and not being drained, the new sweep is dropped and overflow pulses; the held record is unchanged.
  - A load in the same cycle as a transfer is allowed, so back-to-back sweeps are not dropped.
- Reset values: all outputs 0; state IDLE; tick 0; in_pulse 0; history cleared.

## Timing
- sensor_i is sampled low first at edge E0. The fall is detected in the cycle after E1, and sweep_valid is high after E2. Latency is 3 edges.
- sync_locked rises one cycle after the detected fall of a non-skip sync.
- The synchronizer delay is identical for rise and fall, so duration and width are exact in cycles (±1 from input sampling).
- Timeout check is registered: sync_locked falls after the edge where tick − ref_ts first equals SWEEP_WINDOW.
- Reset asserted mid-pulse clears everything immediately. The trailing fall after release is ignored (in_pulse = 0).

## Test plan
- Sync W = 3125, then a sweep rising 200000 cycles after the sync rise, W = 300. Expect one record: duration 200000, axis 0, data 0, lighthouse 0, width 300, sync_locked high.
- Sync W = 5208 (skip), then 8000 cycles rise-to-rise a sync W = 3646 (axis 1), then a sweep 100000 cycles after the second rise. Expect duration 100000, axis 1, lighthouse 1.
- While LOCKED, send a 5-cycle glitch and a 1500-cycle pulse. Expect no record, no overflow, and ref_ts unchanged (a following sweep still reports the original reference).
- Sync W = 3125, then no pulse. Expect sync_locked to fall exactly 420000 cycles after the sync rise; a sweep at 430000 produces no record.
- Hold sweep_ready = 0 and send two sweeps at 50000 and 60000. Expect the first record held (duration 50000), overflow to pulse once at the second fall, and one transfer after ready rises.
- Assert reset 1000 cycles into a W = 3125 sync and release while the pulse is high. Expect all outputs 0 and no lock from the trailing fall; a subsequent clean sync locks normally.
